// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory-arbiter FSM encoding, port owner ids and
// default bus widths.
package cpu_pkg;

  localparam int AW_DEFAULT = 8;
  localparam int DW_DEFAULT = 8;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with a zero flag; times out the memory read latency
// while the arbiter sits in WAIT.
module mem_lat_counter #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between fetch and data stages.
// Define ARB_FAIRNESS_EN to force a fetch grant after MAX_DATA_RUN data grants.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int AW           = AW_DEFAULT,
  parameter int DW           = DW_DEFAULT,
  parameter int MEM_LAT      = 2,
  parameter int MAX_DATA_RUN = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall_if
);

  localparam int CW = cnt_width(MEM_LAT);

  if (MEM_LAT < 1 || MAX_DATA_RUN < 1) begin : g_param_check
    $error("mem_port_arbiter: MEM_LAT and MAX_DATA_RUN must be >= 1");
  end

  logic [1:0] state;
  logic       owner;
  logic       sample_en;
  logic       grant;
  logic       grant_d;
  logic       lat_zero;

`ifdef ARB_FAIRNESS_EN
  localparam int RW = cnt_width(MAX_DATA_RUN + 1);
  logic [RW-1:0] run;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    sample_en = (state == IDLE) || (state == RESP);
    grant_d   = d_req;
`ifdef ARB_FAIRNESS_EN
    // A long data run yields one slot to a waiting fetch.
    if (if_req && d_req && run == RW'(MAX_DATA_RUN)) grant_d = 1'b0;
`endif
    grant     = sample_en && (if_req || d_req);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= OWNER_IF;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (grant) begin
            state    <= ISSUE;
            owner    <= grant_d ? OWNER_D : OWNER_IF;
            mem_addr <= grant_d ? d_addr : if_addr;
            mem_re   <= !(grant_d && d_we);
            mem_we   <= grant_d && d_we;
            if (grant_d) mem_wdata <= d_wdata;
          end else begin
            state <= IDLE;
          end
        end
        // mem_we still reflects the strobe being issued this cycle.
        ISSUE:   state <= mem_we ? RESP : WAIT;
        WAIT:    if (lat_zero) state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is parked per requester and held until that requester's next load.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      if_rdata <= '0;
      d_rdata  <= '0;
    end else if (state == WAIT && lat_zero) begin
      if (owner == OWNER_D) d_rdata <= mem_rdata;
      else                  if_rdata <= mem_rdata;
    end
  end

`ifdef ARB_FAIRNESS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      run <= '0;
    end else if (!if_req || (grant && !grant_d)) begin
      run <= '0;
    end else if (grant && run != RW'(MAX_DATA_RUN)) begin
      run <= run + RW'(1);
    end
  end
`endif

  mem_lat_counter #(.W(CW)) u_lat (
    .clock    (clock),
    .reset    (reset),
    .load     (state == ISSUE && mem_re),
    .load_val (CW'(MEM_LAT - 1)),
    .dec      (state == WAIT),
    .zero     (lat_zero)
  );

  assign if_gnt   = (state == ISSUE) && (owner == OWNER_IF);
  assign d_gnt    = (state == ISSUE) && (owner == OWNER_D);
  assign if_valid = (state == RESP)  && (owner == OWNER_IF);
  assign d_valid  = (state == RESP)  && (owner == OWNER_D);
  assign stall_if = if_req && !if_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a MEM_LAT=2 instance for the main
// scenarios and a MEM_LAT=1 instance for back-to-back loads.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset, reset1;
  logic       if_req, d_req, d_we;
  logic [7:0] if_addr, d_addr, d_wdata;

  logic       if_gnt, if_valid, d_gnt, d_valid, mem_re, mem_we, stall_if;
  logic [7:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       if_gnt_1, if_valid_1, d_gnt_1, d_valid_1, mem_re_1, mem_we_1, stall_if_1;
  logic [7:0] if_rdata_1, d_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;

  mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(2), .MAX_DATA_RUN(3)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_if(stall_if)
  );

  mem_port_arbiter #(.AW(8), .DW(8), .MEM_LAT(1), .MAX_DATA_RUN(3)) dut1 (
    .clock(clock), .reset(reset1),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_1), .if_valid(if_valid_1), .if_rdata(if_rdata_1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt_1), .d_valid(d_valid_1), .d_rdata(d_rdata_1),
    .mem_re(mem_re_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1), .mem_wdata(mem_wdata_1),
    .mem_rdata(mem_rdata_1), .stall_if(stall_if_1)
  );

  // Memory models: data appears exactly MEM_LAT cycles after mem_re, 8'hEE otherwise.
  logic [7:0] ma [256];
  logic [7:0] mb [256];
  logic       init_done = 1'b0;
  logic       a0_v, a1_v, b0_v;
  logic [7:0] a0_d, a1_d, b0_d;

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 8'hA5 : (a ^ 8'h5A);
  endfunction

  always @(posedge clock) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) begin
        ma[i] <= init_val(8'(i));
        mb[i] <= init_val(8'(i));
      end
      a0_v <= 1'b0; a1_v <= 1'b0; b0_v <= 1'b0;
      a0_d <= 8'h00; a1_d <= 8'h00; b0_d <= 8'h00;
      init_done <= 1'b1;
    end else begin
      if (mem_we)   ma[mem_addr]   <= mem_wdata;
      if (mem_we_1) mb[mem_addr_1] <= mem_wdata_1;
      a0_v <= mem_re;   a0_d <= ma[mem_addr];
      a1_v <= a0_v;     a1_d <= a0_d;
      b0_v <= mem_re_1; b0_d <= mb[mem_addr_1];
    end
  end

  assign mem_rdata   = a1_v ? a1_d : 8'hEE;
  assign mem_rdata_1 = b0_v ? b0_d : 8'hEE;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] ifq [$];
  logic [7:0] dq  [$];
  logic [7:0] dq1 [$];
  bit         gq  [$];
  logic [7:0] sh  [256];
  logic [7:0] last_load;
  logic [4:0] exp_order;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe outputs mid-cycle and retire scoreboard entries on valid pulses.
  task automatic sample();
    @(negedge clock);
    if (if_valid) begin
      if (ifq.size() == 0) check("if_valid_unexpected", 32'(if_valid), 32'd0);
      else check("if_rdata", 32'(if_rdata), 32'(ifq.pop_front()));
    end
    if (d_valid) begin
      if (dq.size() == 0) check("d_valid_unexpected", 32'(d_valid), 32'd0);
      else check("d_rdata", 32'(d_rdata), 32'(dq.pop_front()));
    end
    if (d_valid_1) begin
      if (dq1.size() == 0) check("d_valid_1_unexpected", 32'(d_valid_1), 32'd0);
      else check("d_rdata_1", 32'(d_rdata_1), 32'(dq1.pop_front()));
    end
    if (if_gnt || d_gnt) gq.push_back(d_gnt);
  endtask

  task automatic advance();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    int vc, prev_vc;
    bit got;
    reset = 1'b0; reset1 = 1'b0;
    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 8'h00; d_addr = 8'h00; d_wdata = 8'h00;
    last_load = 8'h00;
    for (int i = 0; i < 256; i++) sh[i] = init_val(8'(i));
    advance(); advance();

    // Reset state: outputs low, stall_if follows if_req.
    if_req = 1'b1;
    sample();
    check("rst_stall_follows_req", 32'(stall_if), 32'd1);
    check("rst_strobes", 32'({if_gnt, if_valid, d_gnt, d_valid, mem_re, mem_we}), 32'd0);
    check("rst_data", {mem_addr, mem_wdata, if_rdata, d_rdata}, 32'd0);
    advance();
    if_req = 1'b0;
    sample();
    check("rst_stall_low", 32'(stall_if), 32'd0);
    advance();
    reset = 1'b1;
    sample();
    check("idle_strobes", 32'({if_gnt, if_valid, d_gnt, d_valid, mem_re, mem_we}), 32'd0);
    advance();

    // 1: fetch-only read, MEM_LAT=2.
    if_req = 1'b1; if_addr = 8'h10; ifq.push_back(sh[8'h10]);
    for (int k = 0; k <= 4; k++) begin
      sample();
      check($sformatf("t1_if_gnt_c%0d", k), 32'(if_gnt), 32'(k == 1));
      check($sformatf("t1_mem_re_c%0d", k), 32'(mem_re), 32'(k == 1));
      check($sformatf("t1_if_valid_c%0d", k), 32'(if_valid), 32'(k == 4));
      if (k == 1) check("t1_mem_addr", 32'(mem_addr), 32'h10);
      if (k == 4) check("t1_if_rdata", 32'(if_rdata), 32'hA5);
      advance();
      if (k == 1) if_req = 1'b0;
    end

    // 2: store completes in two cycles, never strobes mem_re, leaves d_rdata alone.
    d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h3C;
    sh[8'h20] = 8'h3C; dq.push_back(last_load);
    for (int k = 0; k <= 2; k++) begin
      sample();
      check($sformatf("t2_d_gnt_c%0d", k), 32'(d_gnt), 32'(k == 1));
      check($sformatf("t2_mem_we_c%0d", k), 32'(mem_we), 32'(k == 1));
      check($sformatf("t2_mem_re_c%0d", k), 32'(mem_re), 32'd0);
      check($sformatf("t2_d_valid_c%0d", k), 32'(d_valid), 32'(k == 2));
      if (k == 1) check("t2_addr_wdata", {16'h0, mem_addr, mem_wdata}, 32'h203C);
      advance();
      if (k == 1) begin d_req = 1'b0; d_we = 1'b0; end
    end

    // 3: simultaneous requests: data first, fetch after its RESP.
    d_req = 1'b1; d_addr = 8'h20; if_req = 1'b1; if_addr = 8'h11;
    dq.push_back(sh[8'h20]); last_load = sh[8'h20]; ifq.push_back(sh[8'h11]);
    for (int k = 0; k <= 8; k++) begin
      sample();
      check($sformatf("t3_d_gnt_c%0d", k), 32'(d_gnt), 32'(k == 1));
      check($sformatf("t3_if_gnt_c%0d", k), 32'(if_gnt), 32'(k == 5));
      check($sformatf("t3_d_valid_c%0d", k), 32'(d_valid), 32'(k == 4));
      check($sformatf("t3_if_valid_c%0d", k), 32'(if_valid), 32'(k == 8));
      check($sformatf("t3_stall_c%0d", k), 32'(stall_if), 32'(k <= 5));
      if (k == 5) check("t3_fetch_addr", 32'(mem_addr), 32'h11);
      advance();
      if (k == 1) d_req = 1'b0;
      if (k == 5) if_req = 1'b0;
    end

    // 4: both requests held high; grant order depends on fairness.
`ifdef ARB_FAIRNESS_EN
    exp_order = 5'b10111;
`else
    exp_order = 5'b11111;
`endif
    gq.delete();
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h30; if_req = 1'b1; if_addr = 8'h31;
    for (int i = 0; i < 5; i++) begin
      if (exp_order[i]) dq.push_back(sh[8'h30]);
      else ifq.push_back(sh[8'h31]);
    end
    last_load = sh[8'h30];
    for (int k = 0; k <= 24; k++) begin
      sample();
      advance();
      if (k == 19) begin d_req = 1'b0; if_req = 1'b0; end
    end
    check("t4_grant_count", 32'(gq.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < gq.size()) check($sformatf("t4_grant_%0d_is_data", i), 32'(gq[i]), 32'(exp_order[i]));
    end
    check("t4_queues_drained", 32'(dq.size() + ifq.size()), 32'd0);

    // 5: reset during WAIT abandons the load.
    d_req = 1'b1; d_addr = 8'h40; dq.push_back(sh[8'h40]);
    for (int k = 0; k <= 2; k++) begin
      sample();
      advance();
      if (k == 1) d_req = 1'b0;
    end
    reset = 1'b0;
    dq.delete();
    last_load = 8'h00;
    sample();
    check("t5_strobes", 32'({if_gnt, if_valid, d_gnt, d_valid, mem_re, mem_we, stall_if}), 32'd0);
    check("t5_data", {mem_addr, mem_wdata, if_rdata, d_rdata}, 32'd0);
    advance();
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sample();
      check($sformatf("t5_no_valid_%0d", k), 32'({d_valid, if_valid, d_gnt}), 32'd0);
      advance();
    end

    // 6: MEM_LAT=1 back-to-back loads, next request issued the cycle after d_valid.
    reset = 1'b0; reset1 = 1'b1;
    advance();
    prev_vc = 0;
    for (int i = 0; i < 4; i++) begin
      d_req = 1'b1; d_we = 1'b0; d_addr = 8'h50 + 8'(i);
      dq1.push_back(sh[8'h50 + 8'(i)]);
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        sample();
        if (d_gnt_1) got = 1'b1;
        advance();
      end
      check($sformatf("t6_gnt_%0d", i), 32'(got), 32'd1);
      d_req = 1'b0;
      got = 1'b0; vc = 0;
      for (int k = 0; k < 8 && !got; k++) begin
        sample();
        if (d_valid_1) begin got = 1'b1; vc = cyc; end
        advance();
      end
      check($sformatf("t6_valid_%0d", i), 32'(got), 32'd1);
      if (i > 0) check($sformatf("t6_period_%0d", i), 32'(vc - prev_vc), 32'd4);
      prev_vc = vc;
    end
    check("final_queues_drained", 32'(dq.size() + ifq.size() + dq1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
